// File: rtl/tcb_pkg.sv
// Shared TCB bus types: response status encoding.
package tcb_pkg;

  localparam int unsigned TCB_STS_W = 2;

  typedef enum logic [TCB_STS_W-1:0] {
    TCB_STS_OKAY  = 2'b00,
    TCB_STS_RANGE = 2'b01,
    TCB_STS_ALIGN = 2'b10
  } tcb_sts_t;

endpackage

// File: rtl/tcb_vip_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), shifts left while ena is high.
module tcb_vip_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] seed,
  output logic [7:0] lfsr
);

  logic fb;

  assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= seed;
    end else if (ena) begin
      lfsr <= {lfsr[6:0], fb};
    end
  end

endmodule

// File: rtl/tcb_vip_memory.sv
// TCB subordinate memory model with fixed response delay and LFSR-driven
// stall injection; stalls are bounded to STL_MAX consecutive cycles.
module tcb_vip_memory
  import tcb_pkg::*;
#(
  parameter int unsigned ADR     = 8,
  parameter int unsigned DAT     = 32,
  parameter int unsigned SIZE    = 128,
  parameter int unsigned DLY     = 1,
  parameter int unsigned STL     = 1,
  parameter int unsigned STL_MAX = 3,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  output logic             rdy,
  input  logic             wen,
  input  logic [ADR-1:0]   adr,
  input  logic [DAT/8-1:0] byt,
  input  logic [DAT-1:0]   wdt,
  output logic [DAT-1:0]   rdt,
  output logic [1:0]       sts
);

  localparam int unsigned BYT   = DAT / 8;
  localparam int unsigned LB    = $clog2(BYT);
  localparam int unsigned WORDS = SIZE / BYT;
  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned AW1   = ADR + 1;

  localparam logic [ADR-1:0] ALIGN_MASK = ADR'(BYT - 1);
  localparam logic [AW1-1:0] SIZE_LIM   = AW1'(SIZE);
  localparam logic [3:0]     SCNT_MAX   = 4'(STL_MAX);

  typedef struct packed {
    logic           act;
    logic           wen;
    logic [1:0]     sts;
    logic [DAT-1:0] rdt;
  } rsp_t;

  logic [DAT-1:0] mem [WORDS];

  logic           trn;
  logic [IW-1:0]  widx;
  tcb_sts_t       req_sts;
  logic           mem_we;
  rsp_t           rsp_in;
  rsp_t           rsp_last;

  logic [7:0]     lfsr;
  logic           lfsr_unused;
  logic           raw_rdy;
  logic [3:0]     scnt;

  // Stall generator: pseudo-random ready, forced high after STL_MAX stalls.
  tcb_vip_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .ena  (vld),
    .seed (SEED),
    .lfsr (lfsr)
  );

  assign raw_rdy     = (lfsr[1:0] != 2'b00);
  assign lfsr_unused = ^lfsr[7:2];
  assign rdy         = ~rst & ((STL == 0) | raw_rdy | (scnt == SCNT_MAX));
  assign trn         = vld & rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt <= 4'd0;
    end else if (!vld || trn) begin
      scnt <= 4'd0;
    end else begin
      scnt <= scnt + 4'd1;
    end
  end

  // Status decode: misalignment takes priority over out-of-range.
  always_comb begin
    req_sts = TCB_STS_OKAY;
    if ((adr & ALIGN_MASK) != '0) begin
      req_sts = TCB_STS_ALIGN;
    end else if ({1'b0, adr} >= SIZE_LIM) begin
      req_sts = TCB_STS_RANGE;
    end
  end

  assign widx   = adr[LB +: IW];
  assign mem_we = trn & wen & (req_sts == TCB_STS_OKAY);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned l = 0; l < BYT; l++) begin
        if (byt[l]) begin
          mem[widx][8*l +: 8] <= wdt[8*l +: 8];
        end
      end
    end
  end

  // Response captured in the transfer cycle; read data only for OKAY reads.
  always_comb begin
    rsp_in     = '0;
    rsp_in.act = trn;
    rsp_in.wen = wen;
    rsp_in.sts = req_sts;
    if (!wen && (req_sts == TCB_STS_OKAY)) begin
      rsp_in.rdt = mem[widx];
    end
  end

  for (genvar i = 0; i < DLY; i++) begin : g_pipe
    rsp_t q;
    if (i == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= rsp_in;
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= g_pipe[i-1].q;
      end
    end
  end

  assign rsp_last = g_pipe[DLY-1].q;
  assign rdt      = (rsp_last.act && !rsp_last.wen) ? rsp_last.rdt : '0;
  assign sts      = rsp_last.act ? rsp_last.sts : 2'b00;

endmodule

// File: tb/tb_tcb_vip_memory.sv
// Bench: three memory instances (DLY 1/2/3, stalls only on the third) on a
// shared request bus, checked against a cycle-level reference model.
module tb_tcb_vip_memory;

  localparam int unsigned NDUT    = 3;
  localparam int unsigned SIZE    = 128;
  localparam int unsigned STL_MAX = 3;
  localparam logic [7:0]  SEED    = 8'hA5;
  localparam int unsigned NV      = 10;

  logic        clk;
  logic        rst;
  logic        vld;
  logic        wen;
  logic [7:0]  adr;
  logic [3:0]  byt;
  logic [31:0] wdt;
  logic        rdy_a, rdy_b, rdy_c;
  logic [31:0] rdt_a, rdt_b, rdt_c;
  logic [1:0]  sts_a, sts_b, sts_c;

  tcb_vip_memory #(.DLY(1), .STL(0)) dut_a (
    .clk(clk), .rst(rst), .vld(vld), .rdy(rdy_a), .wen(wen), .adr(adr),
    .byt(byt), .wdt(wdt), .rdt(rdt_a), .sts(sts_a)
  );
  tcb_vip_memory #(.DLY(2), .STL(0)) dut_b (
    .clk(clk), .rst(rst), .vld(vld), .rdy(rdy_b), .wen(wen), .adr(adr),
    .byt(byt), .wdt(wdt), .rdt(rdt_b), .sts(sts_b)
  );
  tcb_vip_memory #(.DLY(3), .STL(1)) dut_c (
    .clk(clk), .rst(rst), .vld(vld), .rdy(rdy_c), .wen(wen), .adr(adr),
    .byt(byt), .wdt(wdt), .rdt(rdt_c), .sts(sts_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [7:0]  adr;
    logic [3:0]  byt;
    logic [31:0] wdt;
    logic [1:0]  exp_sts;
    logic [31:0] exp_rdt;
  } vec_t;

  vec_t tab [NV];

  int          tests;
  int          fails;
  int unsigned cyc;
  int unsigned srun;
  int unsigned ctrn;

  logic [7:0]  mmem [NDUT][SIZE];
  int unsigned lf   [NDUT];
  int unsigned sc   [NDUT];
  bit          ract [NDUT][8];
  logic [1:0]  rsts [NDUT][8];
  logic [31:0] rrdt [NDUT][8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned lfsr_next(input int unsigned l);
    int unsigned fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 32'hFF;
  endfunction

  function automatic logic [1:0] sts_of(input logic [7:0] a);
    if (a[1:0] != 2'b00) return 2'b10;
    if (32'(a) >= SIZE) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset(input int d);
    lf[d] = 32'(SEED);
    sc[d] = 0;
    for (int s = 0; s < 8; s++) ract[d][s] = 1'b0;
  endtask

  // One clock cycle: check outputs at negedge, advance the model, return after posedge.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      logic        r_act;
      logic [31:0] d_act;
      logic [1:0]  s_act;
      bit          e_rdy;
      bit          trn;
      int unsigned slot;
      int unsigned a;
      logic [1:0]  es;
      logic [31:0] ed;
      r_act = (d == 0) ? rdy_a : (d == 1) ? rdy_b : rdy_c;
      d_act = (d == 0) ? rdt_a : (d == 1) ? rdt_b : rdt_c;
      s_act = (d == 0) ? sts_a : (d == 1) ? sts_b : sts_c;
      slot  = cyc % 8;
      e_rdy = !rst && (d != 2 || (lf[d] & 3) != 0 || sc[d] == STL_MAX);
      check($sformatf("rdy[%0d]", d), 32'(r_act), 32'(e_rdy));
      check($sformatf("rdt[%0d]", d), d_act, ract[d][slot] ? rrdt[d][slot] : 32'h0);
      check($sformatf("sts[%0d]", d), 32'(s_act), ract[d][slot] ? 32'(rsts[d][slot]) : 32'h0);
      ract[d][slot] = 1'b0;
      if (rst) begin
        model_reset(d);
      end else begin
        trn = vld && e_rdy;
        if (trn) begin
          es = sts_of(adr);
          ed = 32'h0;
          a  = 32'(adr);
          if (es == 2'b00) begin
            if (wen) begin
              for (int i = 0; i < 4; i++) if (byt[i]) mmem[d][a+i] = wdt[8*i +: 8];
            end else begin
              ed = {mmem[d][a+3], mmem[d][a+2], mmem[d][a+1], mmem[d][a]};
            end
          end
          slot = (cyc + 32'(d) + 1) % 8;
          ract[d][slot] = 1'b1;
          rsts[d][slot] = es;
          rrdt[d][slot] = ed;
        end
        if (vld) lf[d] = lfsr_next(lf[d]);
        sc[d] = (!vld || trn) ? 0 : sc[d] + 1;
      end
    end
    if (vld && !rdy_c && !rst) begin
      srun++;
      check("stall_run", 32'(srun <= STL_MAX), 32'd1);
    end else begin
      srun = 0;
    end
    if (vld && rdy_c) ctrn++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req();
    vld = ($urandom % 4) != 0;
    wen = 1'($urandom);
    adr = (($urandom % 8) == 0) ? 8'($urandom) : {5'($urandom), 2'b00};
    byt = 4'($urandom);
    wdt = $urandom;
  endtask

  initial begin
    int unsigned pre;
    int unsigned n;
    tests = 0; fails = 0; cyc = 0; srun = 0; ctrn = 0;
    rst = 1'b1; vld = 1'b0; wen = 1'b0; adr = '0; byt = '0; wdt = '0;

    tab[0] = '{1'b1, 8'h04, 4'hF, 32'hCAFE0004, 2'b00, 32'h0};
    tab[1] = '{1'b1, 8'h10, 4'hF, 32'hDEADBEEF, 2'b00, 32'h0};
    tab[2] = '{1'b0, 8'h10, 4'hF, 32'h0,        2'b00, 32'hDEADBEEF};
    tab[3] = '{1'b1, 8'h20, 4'hF, 32'h11223344, 2'b00, 32'h0};
    tab[4] = '{1'b1, 8'h20, 4'h5, 32'hAABBCCDD, 2'b00, 32'h0};
    tab[5] = '{1'b0, 8'h20, 4'h0, 32'h0,        2'b00, 32'h11BB33DD};
    tab[6] = '{1'b1, 8'h82, 4'hF, 32'h12345678, 2'b10, 32'h0};
    tab[7] = '{1'b1, 8'h84, 4'hF, 32'h87654321, 2'b01, 32'h0};
    tab[8] = '{1'b0, 8'h82, 4'hF, 32'h0,        2'b10, 32'h0};
    tab[9] = '{1'b0, 8'h04, 4'hF, 32'h0,        2'b00, 32'hCAFE0004};

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) model_reset(d);
    tick();
    rst = 1'b0;

    // Preload every word so later random reads return defined data.
    for (int w = 0; w < 32; w++) begin
      vld = 1'b1; wen = 1'b1; adr = {5'(w), 2'b00}; byt = 4'hF; wdt = $urandom;
      pre = ctrn; n = 0;
      while (ctrn == pre && n < 16) begin tick(); n++; end
      check("preload_trn", 32'(ctrn != pre), 32'd1);
    end
    vld = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < NV; i++) begin
      vld = 1'b1; wen = tab[i].wen; adr = tab[i].adr; byt = tab[i].byt; wdt = tab[i].wdt;
      tick();
      check($sformatf("vec%0d_sts", i), 32'(sts_a), 32'(tab[i].exp_sts));
      check($sformatf("vec%0d_rdt", i), rdt_a, tab[i].exp_rdt);
    end
    vld = 1'b0;
    repeat (5) tick();

    // Back-to-back reads with vld held high; request held until dut_c accepts.
    vld = 1'b1; wen = 1'b0; byt = 4'hF; adr = {5'($urandom), 2'b00};
    pre = ctrn; n = 0;
    while ((ctrn - pre) < 20 && n < 100) begin
      int unsigned c0;
      c0 = ctrn;
      tick();
      n++;
      if (ctrn != c0) adr = {5'($urandom), 2'b00};
    end
    check("stall_reads", 32'((ctrn - pre) >= 20), 32'd1);
    vld = 1'b0;
    repeat (5) tick();

    rand_req();
    for (int k = 0; k < 300; k++) begin
      int unsigned c0;
      c0 = ctrn;
      tick();
      if (!vld || ctrn != c0) rand_req();
    end
    vld = 1'b0;
    repeat (5) tick();

    // Reset one cycle after a read transfer drops the pending response.
    vld = 1'b1; wen = 1'b0; adr = 8'h10; byt = 4'hF;
    tick();
    vld = 1'b0; rst = 1'b1;
    #1;
    check("rst_rdy_a", 32'(rdy_a), 32'd0);
    check("rst_rdy_c", 32'(rdy_c), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_rdt_b", rdt_b, 32'h0);
    check("post_rst_sts_b", 32'(sts_b), 32'h0);
    check("post_rst_rdy_a", 32'(rdy_a), 32'd1);
    check("post_rst_rdy_b", 32'(rdy_b), 32'd1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
